// File: rtl/pixel_scan_sequencer.sv
// Two-pass image scan address sequencer for the binarization datapath.
// Ports: clk, rst_n, start in; rd_en/rd_addr, pix_valid/pix_addr/pix_last, pass2, busy, done, reallydone out.
module pixel_scan_sequencer #(
    parameter int IMG_W  = 256,
    parameter int IMG_H  = 256,
    parameter int ADDR_W = 16,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              pix_valid,
    output logic [ADDR_W-1:0] pix_addr,
    output logic              pix_last,
    output logic              pass2,
    output logic              busy,
    output logic              done,
    output logic              reallydone
);

    localparam int                N    = IMG_W * IMG_H;
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(N - 1);

    typedef enum logic [2:0] {
        IDLE,
        RD1,
        DRAIN1,
        RD2,
        DRAIN2,
        FIN
    } state_t;

    state_t            state;
    logic [1:0]        rst_sync;
    logic [RD_LAT-1:0] v_q;
    logic [RD_LAT-1:0] l_q;
    logic [ADDR_W-1:0] a_q [RD_LAT];
    logic              rd_last;

    // Reset release is resynchronized; FSM stays idle until it settles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_sync <= 2'b00;
        end else begin
            rst_sync <= {rst_sync[0], 1'b1};
        end
    end

    assign rd_last = rd_en && (rd_addr == LAST);

    // Read-latency alignment: final stage is the registered pix_* output.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_q <= '0;
            l_q <= '0;
            for (int i = 0; i < RD_LAT; i++) begin
                a_q[i] <= '0;
            end
        end else begin
            v_q[0] <= rd_en;
            l_q[0] <= rd_last;
            a_q[0] <= rd_addr;
            for (int i = 1; i < RD_LAT; i++) begin
                v_q[i] <= v_q[i-1];
                l_q[i] <= l_q[i-1];
                a_q[i] <= a_q[i-1];
            end
        end
    end

    assign pix_valid = v_q[RD_LAT-1];
    assign pix_last  = l_q[RD_LAT-1];
    assign pix_addr  = a_q[RD_LAT-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            rd_en      <= 1'b0;
            rd_addr    <= '0;
            pass2      <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            reallydone <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE, FIN: begin
                    if (start && rst_sync[1]) begin
                        state      <= RD1;
                        rd_en      <= 1'b0;
                        rd_addr    <= '0;
                        pass2      <= 1'b0;
                        reallydone <= 1'b0;
                        busy       <= 1'b1;
                    end
                end
                RD1, RD2: begin
                    // First cycle in a read state raises rd_en at address 0.
                    if (!rd_en) begin
                        rd_en <= 1'b1;
                    end else if (rd_addr == LAST) begin
                        rd_en <= 1'b0;
                        state <= (state == RD1) ? DRAIN1 : DRAIN2;
                    end else begin
                        rd_addr <= rd_addr + 1'b1;
                    end
                end
                DRAIN1: begin
                    if (pix_valid && pix_last) begin
                        done    <= 1'b1;
                        pass2   <= 1'b1;
                        rd_addr <= '0;
                        state   <= RD2;
                    end
                end
                DRAIN2: begin
                    if (pix_valid && pix_last) begin
                        reallydone <= 1'b1;
                        busy       <= 1'b0;
                        state      <= FIN;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pixel_scan_sequencer.sv
// Bench for pixel_scan_sequencer: three configurations, per-cycle expected
// outputs derived from the scan timing, queued at drive time and popped at sample.
module tb_pixel_scan_sequencer;

    typedef struct packed {
        logic        rd_en;
        logic [15:0] rd_addr;
        logic        pix_valid;
        logic [15:0] pix_addr;
        logic        pix_last;
        logic        pass2;
        logic        busy;
        logic        done;
        logic        reallydone;
    } obs_t;

    typedef struct {
        int inst;
        int s0;
        int s1;
        int s2;
        int cycles;
    } rec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    int   sel = 0;
    int   checks = 0;
    int   errors = 0;
    obs_t obs;
    obs_t sb [$];
    rec_t tbl [5];

    always #5 clk = ~clk;

    logic       a_rd_en, a_pv, a_pl, a_p2, a_busy, a_done, a_rdone;
    logic [2:0] a_ra, a_pa;
    logic       b_rd_en, b_pv, b_pl, b_p2, b_busy, b_done, b_rdone;
    logic [0:0] b_ra, b_pa;
    logic        c_rd_en, c_pv, c_pl, c_p2, c_busy, c_done, c_rdone;
    logic [11:0] c_ra, c_pa;

    pixel_scan_sequencer #(.IMG_W(4), .IMG_H(2), .ADDR_W(3), .RD_LAT(2)) u_a (
        .clk(clk), .rst_n(rst_n), .start(start),
        .rd_en(a_rd_en), .rd_addr(a_ra), .pix_valid(a_pv), .pix_addr(a_pa),
        .pix_last(a_pl), .pass2(a_p2), .busy(a_busy), .done(a_done),
        .reallydone(a_rdone)
    );

    pixel_scan_sequencer #(.IMG_W(1), .IMG_H(1), .ADDR_W(1), .RD_LAT(1)) u_b (
        .clk(clk), .rst_n(rst_n), .start(start),
        .rd_en(b_rd_en), .rd_addr(b_ra), .pix_valid(b_pv), .pix_addr(b_pa),
        .pix_last(b_pl), .pass2(b_p2), .busy(b_busy), .done(b_done),
        .reallydone(b_rdone)
    );

    pixel_scan_sequencer #(.IMG_W(64), .IMG_H(64), .ADDR_W(12), .RD_LAT(4)) u_c (
        .clk(clk), .rst_n(rst_n), .start(start),
        .rd_en(c_rd_en), .rd_addr(c_ra), .pix_valid(c_pv), .pix_addr(c_pa),
        .pix_last(c_pl), .pass2(c_p2), .busy(c_busy), .done(c_done),
        .reallydone(c_rdone)
    );

    always_comb begin
        obs = '0;
        case (sel)
            0: obs = '{a_rd_en, 16'(a_ra), a_pv, 16'(a_pa), a_pl,
                       a_p2, a_busy, a_done, a_rdone};
            1: obs = '{b_rd_en, 16'(b_ra), b_pv, 16'(b_pa), b_pl,
                       b_p2, b_busy, b_done, b_rdone};
            default: obs = '{c_rd_en, 16'(c_ra), c_pv, 16'(c_pa), c_pl,
                             c_p2, c_busy, c_done, c_rdone};
        endcase
    end

    function automatic int n_of(int i);
        return (i == 0) ? 8 : (i == 1) ? 1 : 4096;
    endfunction

    function automatic int l_of(int i);
        return (i == 0) ? 2 : (i == 1) ? 1 : 4;
    endfunction

    // Expected outputs t edges after the accepted start (n pixels, latency l).
    function automatic obs_t model(int t, int n, int l);
        obs_t m;
        int   d;
        int   r2;
        int   v2;
        int   fin;
        m   = '0;
        d   = n + l + 1;
        r2  = n + l + 2;
        v2  = n + 2 * l + 2;
        fin = 2 * n + 2 * l + 2;
        if (t < 0) return m;
        m.rd_en      = (t >= 1 && t <= n) || (t >= r2 && t <= r2 + n - 1);
        m.rd_addr    = (t <= n) ? 16'(t - 1) : 16'(t - r2);
        m.pix_valid  = (t >= 1 + l && t <= n + l) ||
                       (t >= v2 && t <= v2 + n - 1);
        m.pix_addr   = (t <= n + l) ? 16'(t - 1 - l) : 16'(t - v2);
        m.pix_last   = (t == n + l) || (t == v2 + n - 1);
        m.done       = (t == d);
        m.pass2      = (t >= d);
        m.busy       = (t < fin);
        m.reallydone = (t >= fin);
        return m;
    endfunction

    task automatic check_obs(string nm, int e, obs_t ex, bit full);
        bit bad;
        checks++;
        bad = (obs.rd_en != ex.rd_en) || (obs.pix_valid != ex.pix_valid) ||
              (obs.pix_last != ex.pix_last) || (obs.pass2 != ex.pass2) ||
              (obs.busy != ex.busy) || (obs.done != ex.done) ||
              (obs.reallydone != ex.reallydone) ||
              ((full || ex.rd_en) && obs.rd_addr != ex.rd_addr) ||
              ((full || ex.pix_valid) && obs.pix_addr != ex.pix_addr);
        if (bad) begin
            errors++;
            $display("FAIL %s edge %0d got en=%b ra=%0d pv=%b pa=%0d pl=%b p2=%b bsy=%b dn=%b rd=%b want en=%b ra=%0d pv=%b pa=%0d pl=%b p2=%b bsy=%b dn=%b rd=%b",
                     nm, e, obs.rd_en, obs.rd_addr, obs.pix_valid,
                     obs.pix_addr, obs.pix_last, obs.pass2, obs.busy,
                     obs.done, obs.reallydone, ex.rd_en, ex.rd_addr,
                     ex.pix_valid, ex.pix_addr, ex.pix_last, ex.pass2,
                     ex.busy, ex.done, ex.reallydone);
        end
    endtask

    task automatic check_int(string nm, int act, int ex);
        checks++;
        if (act != ex) begin
            errors++;
            $display("FAIL %s got %0d want %0d", nm, act, ex);
        end
    endtask

    task automatic do_reset(int inst);
        sel = inst;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_obs("reset_state", -1, '0, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic run(int inst, int s0, int s1, int s2, int cycles,
                       string nm);
        int   n;
        int   l;
        int   s_cur;
        int   pv_a, pv_e, dn_a, dn_e, rr_a, rr_e;
        bit   st;
        bit   prev_a, prev_e;
        obs_t ex;
        n = n_of(inst);
        l = l_of(inst);
        sel = inst;
        s_cur = -1;
        pv_a = 0; pv_e = 0; dn_a = 0; dn_e = 0; rr_a = 0; rr_e = 0;
        prev_a = 1'b0;
        prev_e = 1'b0;
        for (int e = 0; e < cycles; e++) begin
            st = (e == s0) || (e == s1) || (e == s2);
            start = st;
            if (st && (s_cur < 0 || e - s_cur >= 2 * n + 2 * l + 3))
                s_cur = e;
            sb.push_back((s_cur < 0) ? obs_t'('0) : model(e - s_cur, n, l));
            @(posedge clk);
            #1;
            start = 1'b0;
            ex = sb.pop_front();
            check_obs(nm, e, ex, 1'b0);
            pv_a += int'(obs.pix_valid);
            pv_e += int'(ex.pix_valid);
            dn_a += int'(obs.done);
            dn_e += int'(ex.done);
            rr_a += int'(obs.reallydone && !prev_a);
            rr_e += int'(ex.reallydone && !prev_e);
            prev_a = obs.reallydone;
            prev_e = ex.reallydone;
        end
        check_int({nm, "_pv_count"}, pv_a, pv_e);
        check_int({nm, "_done_count"}, dn_a, dn_e);
        check_int({nm, "_rdone_rises"}, rr_a, rr_e);
    endtask

    initial begin
        tbl[0] = '{0, 0, 5, 22, 30};
        tbl[1] = '{0, 0, 30, -1, 60};
        tbl[2] = '{1, 0, 3, 7, 16};
        tbl[3] = '{0, 0, 22, 23, 50};
        tbl[4] = '{2, 0, 100, -1, 2 * 4096 + 2 * 4 + 8};

        for (int i = 0; i < 5; i++) begin
            do_reset(tbl[i].inst);
            run(tbl[i].inst, tbl[i].s0, tbl[i].s1, tbl[i].s2,
                tbl[i].cycles, $sformatf("vec%0d", i));
        end

        // Abort mid pass 2: outputs drop without waiting for a clock edge.
        do_reset(0);
        run(0, 0, -1, -1, 14, "pre_abort");
        #2;
        rst_n = 1'b0;
        #1;
        check_obs("async_abort", 14, '0, 1'b1);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            check_obs("abort_hold", 15 + k, '0, 1'b1);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        run(0, 0, -1, -1, 26, "post_abort");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
